// File: rtl/seg_frame_scanner.sv
// seg_frame_scanner
// Time-multiplexed driver for an 8-digit, 7-segment display.
// The display word, masks and brightness are captured once per frame into
// shadow registers, so a scan never shows a half-updated word. Each digit
// slot is divided into 16 PWM sub-slices to give 16 brightness levels.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en           global enable; 0 turns every digit off
//   display      packed hex nibbles, [3:0]=DK0 (rightmost) .. [31:28]=DK7
//   dp_mask      1 = decimal point lit on digit i
//   blank_mask   1 = digit i forced dark
//   brightness   digit is lit for (brightness+1)/16 of each slot
//   led_en       active-low digit select
//   led_cx       active-low segments {dp,g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse on the first output cycle of DK0
module seg_frame_scanner #(
  parameter int SLICE_CYCLES = 6250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] display,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic [3:0]  brightness,
  output logic [7:0]  led_en,
  output logic [7:0]  led_cx,
  output logic        frame_start
);

  localparam int SW = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1;
  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICE_CYCLES - 1);

  logic [SW-1:0] slice_cnt;
  logic [3:0]    sub_cnt;
  logic [2:0]    idx;

  logic [31:0]   display_sh;
  logic [7:0]    dp_sh;
  logic [7:0]    blank_sh;
  logic [3:0]    bright_sh;

  logic          fb;
  logic [31:0]   cur_display;
  logic [7:0]    cur_dp;
  logic [7:0]    cur_blank;
  logic [3:0]    cur_bright;
  logic [3:0]    nibble;
  logic          lit;
  logic [7:0]    en_next;
  logic [7:0]    cx_next;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slice / sub-slice / digit counters. They free-run regardless of en so
  // the frame period stays fixed; reset parks them on a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      slice_cnt <= '0;
      sub_cnt   <= '0;
      idx       <= '0;
    end else if (slice_cnt == SLICE_LAST) begin
      slice_cnt <= '0;
      sub_cnt   <= sub_cnt + 4'd1;
      if (sub_cnt == 4'd15) begin
        idx <= idx + 3'd1;
      end
    end else begin
      slice_cnt <= slice_cnt + SW'(1);
    end
  end

  // On the frame boundary the live inputs drive the output directly, so the
  // first DK0 slice already reflects the values being captured this edge.
  always_comb begin
    fb          = (slice_cnt == '0) && (sub_cnt == 4'd0) && (idx == 3'd0);
    cur_display = fb ? display    : display_sh;
    cur_dp      = fb ? dp_mask    : dp_sh;
    cur_blank   = fb ? blank_mask : blank_sh;
    cur_bright  = fb ? brightness : bright_sh;
    nibble      = cur_display[idx*4 +: 4];
    lit         = en && !cur_blank[idx] && (sub_cnt <= cur_bright);
    en_next     = 8'hFF;
    cx_next     = 8'hFF;
    if (lit) begin
      en_next = ~(8'h01 << idx);
      cx_next = {~cur_dp[idx], seg7(nibble)};
    end
  end

  // Shadow capture and registered outputs. Segments are forced high
  // whenever the digit is dark so no segment line drives an unselected digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_sh  <= '0;
      dp_sh       <= '0;
      blank_sh    <= '0;
      bright_sh   <= '0;
      led_en      <= 8'hFF;
      led_cx      <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      if (fb) begin
        display_sh <= display;
        dp_sh      <= dp_mask;
        blank_sh   <= blank_mask;
        bright_sh  <= brightness;
      end
      led_en      <= en_next;
      led_cx      <= cx_next;
      frame_start <= fb;
    end
  end

endmodule

// File: tb/tb_seg_frame_scanner.sv
// tb_seg_frame_scanner
// Scoreboard bench for seg_frame_scanner with SLICE_CYCLES=2 (slot = 32
// cycles, frame = 256 cycles). The stimulus side predicts each registered
// output from the elapsed time since reset release and pushes it into a
// queue; an independent monitor pops and compares one entry per clock.
module tb_seg_frame_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] display;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [3:0]  brightness;
  logic [7:0]  led_en;
  logic [7:0]  led_cx;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_frame_scanner #(.SLICE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .display    (display),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .brightness (brightness),
    .led_en     (led_en),
    .led_cx     (led_cx),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [7:0] le;
    logic [7:0] cx;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   started = 1'b0;

  // Active-low {g..a} patterns for hex digits 0..F.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: edges since reset release plus the per-frame snapshot.
  int          t = 0;
  logic [31:0] m_disp = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  m_blank = '0;
  logic [3:0]  m_bright = '0;

  // Predict what the DUT registers at the coming edge given current inputs.
  task automatic predict();
    exp_t e;
    int pos, dig, sub;
    bit lit;
    if (rst) begin
      e = '{le: 8'hFF, cx: 8'hFF, fs: 1'b0};
      t = 0;
      m_disp = '0; m_dp = '0; m_blank = '0; m_bright = '0;
    end else begin
      pos = t % 256;
      if (pos == 0) begin
        m_disp = display; m_dp = dp_mask; m_blank = blank_mask; m_bright = brightness;
      end
      dig = pos / 32;
      sub = (pos % 32) / 2;
      lit = en && !m_blank[dig] && (sub <= int'(m_bright));
      e.fs = (pos == 0);
      if (lit) begin
        e.le = ~(8'h01 << dig);
        e.cx = {~m_dp[dig], seg_tab[m_disp[dig*4 +: 4]]};
      end else begin
        e.le = 8'hFF;
        e.cx = 8'hFF;
      end
      t++;
    end
    sb.push_back(e);
    started = 1'b1;
  endtask

  // Run n clock cycles with the inputs as currently driven.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      predict();
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (led_en !== e.le || led_cx !== e.cx || frame_start !== e.fs) begin
      n_err++;
      $display("[TB] FAIL out t=%0t got en=%h cx=%h fs=%b want en=%h cx=%h fs=%b",
               $time, led_en, led_cx, frame_start, e.le, e.cx, e.fs);
    end
  endtask

  // Monitor: every clock presents a new registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end else if (started) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL scoreboard empty at t=%0t got en=%h want an entry", $time, led_en);
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; en = 1'b1; display = '0; dp_mask = '0; blank_mask = '0; brightness = 4'hF;
    applyStimulus(3);
    rst = 1'b0;
    display = 32'h8105_0329; brightness = 4'hF;
    applyStimulus(256 + 3 * 32 + 10);
    display = 32'h0;
    applyStimulus(150 + 256);
    brightness = 4'h3;
    applyStimulus(256 + 100);
    en = 1'b0;
    applyStimulus(45);
    en = 1'b1;
    applyStimulus(300);
    blank_mask = 8'h80; dp_mask = 8'h04; display = 32'h7654_3210; brightness = 4'hF;
    applyStimulus(512);

    for (int ph = 0; ph < 20; ph++) begin
      display    = $urandom;
      dp_mask    = 8'($urandom);
      blank_mask = 8'($urandom) & 8'($urandom);
      brightness = 4'($urandom);
      en         = ($urandom_range(0, 3) != 0);
      if (ph == 11) begin
        rst = 1'b1;
        applyStimulus($urandom_range(1, 4));
        rst = 1'b0;
      end
      applyStimulus($urandom_range(20, 300));
    end
    applyStimulus(256);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
